oai221_bist_ctrl: RTL and testbench
===================================

Name: oai221_bist_ctrl

Overview:
Built-in self-test sequencer for one OAI221 compound gate instance, ZN = !(A & (B1|B2) & (C1|C2)).
- Drives all 32 input vectors exhaustively.
- Waits a programmable settle time per vector, then samples ZN and compares it against an internal golden model.
- Reports pass/fail, a saturating failure count and the first failing vector.
- Sits beside the cell-under-test in the library characterization/test wrapper.

Parameters:
- SETTLE_CYC, 2, settle cycles between applying a vector and sampling ZN. Legal range 0..15; 0 skips the SETTLE state.
- FAIL_W, 6, width of the failure counter. Legal range 1..6. The counter saturates at 2^FAIL_W-1.

Ports:
- CK  input  1  clock (only clock in the block)
- RN  input  1  asynchronous active-low reset
- start  input  1  begin a run; sampled only in IDLE
- abort  input  1  terminate the current run
- dut_a  output  1  to cell A
- dut_b1, dut_b2  output  1 each  to cell B1, B2
- dut_c1, dut_c2  output  1 each  to cell C1, C2
- dut_zn  input  1  cell ZN
- busy  output  1  run in progress
- done  output  1  one-cycle pulse at completion
- pass  output  1  last completed run had zero failures
- fail_cnt  output  FAIL_W  failing-vector count
- first_fail_vec  output  5  index of the first failing vector
- first_fail_valid  output  1  first_fail_vec holds a captured value

Behaviour:
- Reset: one clock CK; RN is asynchronous and active-low. All outputs, the vector index v and the FSM (IDLE) clear to 0 immediately on RN low.
- Vector mapping, with v[4:0] registered:
  - dut_a=v[4], dut_b1=v[3], dut_b2=v[2], dut_c1=v[1], dut_c2=v[0].
  - Outputs are registered. They are 0 in IDLE and DONE.
- Expected response: exp = !(v[4] & (v[3]|v[2]) & (v[1]|v[0])).
- States: IDLE, APPLY, SETTLE, CAPTURE, DONE.
- IDLE:
  - On start=1 and abort=0: v<=0, fail_cnt<=0, first_fail_valid<=0, pass<=0, busy<=1, go to APPLY.
  - start while busy is ignored.
- APPLY: dut_* driven from v for 1 cycle, then go to SETTLE. If SETTLE_CYC=0, go directly to CAPTURE.
- SETTLE: down-counter loaded with SETTLE_CYC. Stay SETTLE_CYC cycles, then go to CAPTURE.
- CAPTURE (1 cycle): compare dut_zn to exp.
  - On mismatch, fail_cnt increments, saturating at 2^FAIL_W-1.
  - On mismatch with first_fail_valid=0: first_fail_vec<=v, first_fail_valid<=1.
  - If v==31, go to DONE; else v<=v+1 and go to APPLY.
  - dut_* hold their value through SETTLE and CAPTURE.
- DONE (1 cycle): done=1, busy<=0, pass<=(fail_cnt==0, including this run's final compare), then go to IDLE.
- Result hold: pass, fail_cnt and first_fail_* hold until the next accepted start.
- Timing:
  - Per vector: SETTLE_CYC+2 cycles.
  - done is high exactly 32*(SETTLE_CYC+2)+1 cycles after the edge that samples start.
- abort:
  - In any non-IDLE state: next state IDLE, busy<=0, dut_*<=0, no done pulse, pass<=0.
  - fail_cnt and first_fail_* keep their partial values.
  - abort beats start in the same cycle.
- Reset mid-run: immediate return to IDLE with all outputs 0; no done.
- v never wraps: the 31→0 transition does not occur within a run.

Optional Feature:
- Macro: OAI221_BIST_SIGNATURE_EN.
- When defined:
  - Adds output sig[15:0], a MISR with polynomial x^16+x^12+x^5+1.
  - Seeded to 16'hFFFF on accepted start.
  - Shifts dut_zn in once per CAPTURE.
  - Holds after DONE or abort; resets to 0.
- When undefined: the sig port and all MISR logic are absent; all other behaviour is identical.

Test Plan:
1. Golden-model cell, SETTLE_CYC=2, start pulse → busy for 128 cycles; done pulse at cycle 129; pass=1, fail_cnt=0, first_fail_valid=0.
2. dut_zn stuck at 1 → fail_cnt=9, first_fail_vec=5'd21 (10101), first_fail_valid=1, pass=0.
3. dut_zn stuck at 0, FAIL_W=4 → failures=23, fail_cnt saturates at 15, first_fail_vec=0, pass=0.
4. SETTLE_CYC=0, golden cell → done 65 cycles after start; dut_* sequence 0..31, each held 2 cycles.
5. abort asserted while v=10 → next cycle IDLE, busy=0, dut_*=0, no done; then start again → full run completes with pass=1.
6. RN pulsed low mid-SETTLE; start and abort asserted together in IDLE → all outputs 0 immediately; simultaneous start+abort leaves the FSM in IDLE with busy=0.

Source files
------------

// File: rtl/oai221_bist_ctrl.sv
// Exhaustive BIST sequencer for one OAI221 cell; optional MISR signature via OAI221_BIST_SIGNATURE_EN.
// Latency: 32*(SETTLE_CYC+2) cycles per run, done one cycle later; registered outputs.
// Backpressure: none; start is accepted only in IDLE, and abort returns to IDLE from any active state.
module oai221_bist_ctrl #(
    parameter int SETTLE_CYC = 2,
    parameter int FAIL_W     = 6
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              start,
    input  logic              abort,
    output logic              dut_a,
    output logic              dut_b1,
    output logic              dut_b2,
    output logic              dut_c1,
    output logic              dut_c2,
    input  logic              dut_zn,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [FAIL_W-1:0] fail_cnt,
    output logic [4:0]        first_fail_vec,
    output logic              first_fail_valid
`ifdef OAI221_BIST_SIGNATURE_EN
    ,
    output logic [15:0]       sig
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        APPLY   = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [3:0]        SETTLE_LD = 4'(SETTLE_CYC);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = '1;

    state_t              state_q, state_d;
    logic [4:0]          v_q, v_d;
    logic [4:0]          vec_q, vec_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [4:0]          ffv_q, ffv_d;
    logic                ffval_q, ffval_d;
    logic                exp_zn;
    logic                mismatch;
    logic                run_abort;
`ifdef OAI221_BIST_SIGNATURE_EN
    logic [15:0]         sig_q, sig_d;
    logic                sig_fb;
`endif

    assign exp_zn    = ~(v_q[4] & (v_q[3] | v_q[2]) & (v_q[1] | v_q[0]));
    assign mismatch  = (dut_zn != exp_zn);
    assign run_abort = abort && (state_q != IDLE);

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !abort) state_d = APPLY;
            APPLY:   state_d = (SETTLE_CYC == 0) ? CAPTURE : SETTLE;
            SETTLE:  if (cnt_q <= 4'd1) state_d = CAPTURE;
            CAPTURE: state_d = (v_q == 5'd31) ? DONE : APPLY;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (run_abort) state_d = IDLE;
    end

    always_comb begin
        v_d        = v_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        fail_cnt_d = fail_cnt_q;
        ffv_d      = ffv_q;
        ffval_d    = ffval_q;
`ifdef OAI221_BIST_SIGNATURE_EN
        sig_fb     = sig_q[15] ^ dut_zn;
        sig_d      = sig_q;
`endif
        if (run_abort) begin
            // Partial results stay visible; only the run control is torn down.
            busy_d = 1'b0;
            vec_d  = 5'd0;
            pass_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        v_d        = 5'd0;
                        vec_d      = 5'd0;
                        busy_d     = 1'b1;
                        pass_d     = 1'b0;
                        fail_cnt_d = '0;
                        ffv_d      = 5'd0;
                        ffval_d    = 1'b0;
`ifdef OAI221_BIST_SIGNATURE_EN
                        sig_d      = 16'hFFFF;
`endif
                    end
                end
                APPLY:  cnt_d = SETTLE_LD;
                SETTLE: cnt_d = cnt_q - 4'd1;
                CAPTURE: begin
`ifdef OAI221_BIST_SIGNATURE_EN
                    sig_d = {sig_q[14:0], 1'b0} ^ ({16{sig_fb}} & 16'h1021);
`endif
                    if (mismatch) begin
                        if (fail_cnt_q != FAIL_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
                        if (!ffval_q) begin
                            ffv_d   = v_q;
                            ffval_d = 1'b1;
                        end
                    end
                    if (v_q == 5'd31) begin
                        // Outputs of the DONE cycle are set up here so done, busy and pass line up.
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        vec_d  = 5'd0;
                        pass_d = (fail_cnt_d == '0);
                    end else begin
                        v_d   = v_q + 5'd1;
                        vec_d = v_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            v_q        <= 5'd0;
            vec_q      <= 5'd0;
            cnt_q      <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_cnt_q <= '0;
            ffv_q      <= 5'd0;
            ffval_q    <= 1'b0;
`ifdef OAI221_BIST_SIGNATURE_EN
            sig_q      <= 16'h0000;
`endif
        end else begin
            v_q        <= v_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_cnt_q <= fail_cnt_d;
            ffv_q      <= ffv_d;
            ffval_q    <= ffval_d;
`ifdef OAI221_BIST_SIGNATURE_EN
            sig_q      <= sig_d;
`endif
        end
    end

    assign dut_a            = vec_q[4];
    assign dut_b1           = vec_q[3];
    assign dut_b2           = vec_q[2];
    assign dut_c1           = vec_q[1];
    assign dut_c2           = vec_q[0];
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign fail_cnt         = fail_cnt_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffval_q;
`ifdef OAI221_BIST_SIGNATURE_EN
    assign sig              = sig_q;
`endif

endmodule

// File: tb/tb_oai221_bist_ctrl.sv
// Bench for oai221_bist_ctrl: three instances cover the default, FAIL_W=4 and SETTLE_CYC=0 builds.
module tb_oai221_bist_ctrl;

    logic       CK = 1'b0;
    logic       RN;
    logic [2:0] start_s, abort_s;
    logic [2:0] busy_s, done_s, pass_s, ffval_s, zn_s;
    logic [4:0] vec0, vec1, vec2;
    logic [4:0] ffv0, ffv1, ffv2;
    logic [5:0] fc0, fc2;
    logic [3:0] fc1;
    int         zn_mode;
    int         checks = 0;
    int         errors = 0;
`ifdef OAI221_BIST_SIGNATURE_EN
    logic [15:0] sig0, sig1, sig2;
`endif

    typedef struct {
        logic       pass;
        logic [5:0] fc;
        logic [4:0] ffv;
        logic       ffval;
        int         lat;
    } exp_t;
    exp_t sbq[$];

    always #5 CK = ~CK;

    function automatic logic gold(input logic [4:0] v);
        return ~(v[4] & (v[3] | v[2]) & (v[1] | v[0]));
    endfunction

    assign zn_s[0] = (zn_mode == 0) ? gold(vec0) : (zn_mode == 1);
    assign zn_s[1] = 1'b0;
    assign zn_s[2] = gold(vec2);

    oai221_bist_ctrl #(.SETTLE_CYC(2), .FAIL_W(6)) u0 (
        .CK(CK), .RN(RN), .start(start_s[0]), .abort(abort_s[0]),
        .dut_a(vec0[4]), .dut_b1(vec0[3]), .dut_b2(vec0[2]), .dut_c1(vec0[1]), .dut_c2(vec0[0]),
        .dut_zn(zn_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .fail_cnt(fc0), .first_fail_vec(ffv0), .first_fail_valid(ffval_s[0])
`ifdef OAI221_BIST_SIGNATURE_EN
        , .sig(sig0)
`endif
    );

    oai221_bist_ctrl #(.SETTLE_CYC(2), .FAIL_W(4)) u1 (
        .CK(CK), .RN(RN), .start(start_s[1]), .abort(abort_s[1]),
        .dut_a(vec1[4]), .dut_b1(vec1[3]), .dut_b2(vec1[2]), .dut_c1(vec1[1]), .dut_c2(vec1[0]),
        .dut_zn(zn_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .fail_cnt(fc1), .first_fail_vec(ffv1), .first_fail_valid(ffval_s[1])
`ifdef OAI221_BIST_SIGNATURE_EN
        , .sig(sig1)
`endif
    );

    oai221_bist_ctrl #(.SETTLE_CYC(0), .FAIL_W(6)) u2 (
        .CK(CK), .RN(RN), .start(start_s[2]), .abort(abort_s[2]),
        .dut_a(vec2[4]), .dut_b1(vec2[3]), .dut_b2(vec2[2]), .dut_c1(vec2[1]), .dut_c2(vec2[0]),
        .dut_zn(zn_s[2]), .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]),
        .fail_cnt(fc2), .first_fail_vec(ffv2), .first_fail_valid(ffval_s[2])
`ifdef OAI221_BIST_SIGNATURE_EN
        , .sig(sig2)
`endif
    );

    function automatic logic [4:0] get_vec(input int i);
        case (i)
            0:       return vec0;
            1:       return vec1;
            default: return vec2;
        endcase
    endfunction

    function automatic logic [4:0] get_ffv(input int i);
        case (i)
            0:       return ffv0;
            1:       return ffv1;
            default: return ffv2;
        endcase
    endfunction

    function automatic logic [5:0] get_fc(input int i);
        case (i)
            0:       return fc0;
            1:       return {2'b00, fc1};
            default: return fc2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference result: mode 0 = healthy cell, 1 = ZN stuck at 1, 2 = ZN stuck at 0.
    task automatic model(input int mode, input int nvec, input int fw,
                         output logic [5:0] fc, output logic [4:0] ffv, output logic ffval);
        int   cnt;
        int   cmax;
        logic zn;
        cnt   = 0;
        cmax  = (1 << fw) - 1;
        ffv   = 5'd0;
        ffval = 1'b0;
        for (int v = 0; v < nvec; v++) begin
            zn = (mode == 0) ? gold(5'(v)) : (mode == 1);
            if (zn != gold(5'(v))) begin
                if (cnt < cmax) cnt++;
                if (!ffval) begin
                    ffv   = 5'(v);
                    ffval = 1'b1;
                end
            end
        end
        fc = 6'(cnt);
    endtask

    task automatic chk_idle_outputs(input int i, input string tag);
        chk({tag, "_busy"},  busy_s[i],  0);
        chk({tag, "_done"},  done_s[i],  0);
        chk({tag, "_pass"},  pass_s[i],  0);
        chk({tag, "_vec"},   get_vec(i), 0);
        chk({tag, "_fc"},    get_fc(i),  0);
        chk({tag, "_ffv"},   get_ffv(i), 0);
        chk({tag, "_ffval"}, ffval_s[i], 0);
    endtask

    task automatic run(input int i, input int mode, input int fw, input int s);
        exp_t e;
        exp_t got;
        bit   seen;
        model(mode, 32, fw, e.fc, e.ffv, e.ffval);
        e.pass = (e.fc == 6'd0);
        e.lat  = 32 * (s + 2) + 1;
        @(negedge CK);
        start_s[i] = 1'b1;
        sbq.push_back(e);
        @(negedge CK);
        start_s[i] = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= e.lat + 4 && !seen; k++) begin
            if (done_s[i]) begin
                seen = 1'b1;
                got  = sbq.pop_front();
                chk("done_latency", k, got.lat);
                chk("busy_at_done", busy_s[i], 0);
                chk("vec_at_done",  get_vec(i), 0);
                chk("pass",         pass_s[i], got.pass);
                chk("fail_cnt",     get_fc(i), got.fc);
                chk("first_fail_vec",   get_ffv(i), got.ffv);
                chk("first_fail_valid", ffval_s[i], got.ffval);
            end else begin
                chk("busy_run", busy_s[i], 1);
                chk("vec_seq",  get_vec(i), (k - 1) / (s + 2));
            end
            @(negedge CK);
        end
        chk("done_seen", seen, 1);
        chk("done_one_cycle", done_s[i], 0);
        chk("pass_hold", pass_s[i], e.pass);
        chk("fc_hold",   get_fc(i), e.fc);
    endtask

    initial begin
        logic [5:0] pfc;
        logic [4:0] pffv;
        logic       pffval;

        RN      = 1'b0;
        start_s = 3'b000;
        abort_s = 3'b000;
        zn_mode = 0;
        repeat (2) @(negedge CK);
        for (int i = 0; i < 3; i++) chk_idle_outputs(i, "reset");
        RN = 1'b1;
        @(negedge CK);

        run(0, 0, 6, 2);            // healthy cell
        zn_mode = 1;
        run(0, 1, 6, 2);            // ZN stuck at 1
        run(1, 2, 4, 2);            // ZN stuck at 0, 4-bit counter saturates
        run(2, 0, 6, 0);            // no settle state

        // Abort at v=10 with a failing cell, then a clean rerun.
        zn_mode = 2;
        @(negedge CK);
        start_s[0] = 1'b1;
        @(negedge CK);
        start_s[0] = 1'b0;
        repeat (40) @(negedge CK);
        chk("abort_at_v10", vec0, 10);
        abort_s[0] = 1'b1;
        @(negedge CK);
        abort_s[0] = 1'b0;
        model(2, 10, 6, pfc, pffv, pffval);
        chk("abort_busy", busy_s[0], 0);
        chk("abort_vec",  vec0, 0);
        chk("abort_done", done_s[0], 0);
        chk("abort_pass", pass_s[0], 0);
        chk("abort_fc_partial",    fc0, pfc);
        chk("abort_ffv_partial",   ffv0, pffv);
        chk("abort_ffval_partial", ffval_s[0], pffval);
        for (int k = 0; k < 6; k++) begin
            @(negedge CK);
            chk("abort_no_done", done_s[0], 0);
            chk("abort_stay_idle", busy_s[0], 0);
        end
        zn_mode = 0;
        run(0, 0, 6, 2);

        // Asynchronous reset in SETTLE, checked before any further clock edge.
        @(negedge CK);
        start_s[0] = 1'b1;
        @(negedge CK);
        start_s[0] = 1'b0;
        @(negedge CK);
        chk("pre_reset_busy", busy_s[0], 1);
        #2 RN = 1'b0;
        #1 chk_idle_outputs(0, "async_reset");
        @(negedge CK);
        RN = 1'b1;
        @(negedge CK);
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        @(negedge CK);
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        chk("start_abort_busy", busy_s[0], 0);
        chk("start_abort_vec",  vec0, 0);
        repeat (3) @(negedge CK);
        chk("start_abort_idle", busy_s[0], 0);
        chk("start_abort_done", done_s[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
